rr_mux_n_1: RTL

//   Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
//   Two selection modes: fixed (external sel) and round-robin arbitration across requesting channels.
//   One output register stage sits between the selection logic and the output.

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/rr_mux_n_1.sv | 78 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin N:1 registered mux.
// Provides mode encodings and a select-width function safe for tiny N_CH.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // $clog2(2) is 1 but $clog2(1) is 0; keep at least one select bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection: fixed index or round-robin search from rr_last+1.
// Ports: clk, rst_n, req, mode, sel, advance -> gnt, gnt_vld.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int SELW = clog2_safe(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic            advance,
    output logic [SELW-1:0] gnt,
    output logic            gnt_vld
);

    logic [SELW-1:0] r_last;
    logic [SELW-1:0] w_idx;
    logic [SELW-1:0] w_rr_gnt;
    logic            w_rr_vld;
    logic            w_fix_vld;

    // Walk from farthest to nearest so the nearest requester after
    // r_last is the last one written and therefore wins.
    always_comb begin
        w_idx    = '0;
        w_rr_gnt = '0;
        w_rr_vld = 1'b0;
        for (int k = N_CH; k >= 1; k--) begin
            w_idx = SELW'((int'(r_last) + k) % N_CH);
            if (req[w_idx]) begin
                w_rr_gnt = w_idx;
                w_rr_vld = 1'b1;
            end
        end
    end

    // An out-of-range select never grants.
    assign w_fix_vld = (int'(sel) < N_CH) && req[sel];

    always_comb begin
        gnt     = sel;
        gnt_vld = w_fix_vld;
        if (mode == MODE_RR) begin
            gnt     = w_rr_gnt;
            gnt_vld = w_rr_vld;
        end
    end

    // Pointer only moves on a round-robin transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SELW'(N_CH - 1);
        end else if (advance && (mode == MODE_RR)) begin
            r_last <= gnt;
        end
    end

endmodule

// File: rtl/rr_mux_n_1.sv
// N_CH-channel, DW-bit registered mux with valid/ready on all sides.
// Ports: mode/sel choose the grant; in_* per channel; out_* registered.
module rr_mux_n_1
    import mux_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int DW   = 8,
    localparam int SELW = clog2_safe(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N_CH-1:0]    in_valid,
    output logic [N_CH-1:0]    in_ready,
    input  logic [N_CH*DW-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [SELW-1:0]    out_ch
);

    logic [SELW-1:0] w_gnt;
    logic            w_gnt_vld;
    logic            w_load;
    logic [DW-1:0]   w_data;

    logic            r_valid;
    logic [DW-1:0]   r_data;
    logic [SELW-1:0] r_ch;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .mode    (mode),
        .sel     (sel),
        .advance (w_load),
        .gnt     (w_gnt),
        .gnt_vld (w_gnt_vld)
    );

    // gnt_vld already implies in_valid[gnt]; the register may refill
    // in the same cycle it drains.
    assign w_load = w_gnt_vld && (!r_valid || out_ready);

    assign in_ready = w_load ? (N_CH'(1) << w_gnt) : '0;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt == SELW'(i)) begin
                w_data = in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_ch    <= w_gnt;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule
